// File: rtl/des_round_engine.sv
// Iterative DES Feistel core: one round per clock, f-function supplied externally.
// Takes {L0,R0} and PC-1 C||D; returns the pre-output block {R16,L16}.
module des_round_engine #(
  parameter int ROUNDS = 16,
  parameter int CNT_W  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] ip_data,
  input  logic [55:0] key_cd,
  input  logic        mode,
  output logic [31:0] f_r,
  output logic [55:0] f_cd,
  input  logic [31:0] f_res,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        busy,
  output logic [3:0]  round_idx
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  // The counter holds the round number modulo 2**CNT_W, so round 16 wraps to 0.
  localparam logic [CNT_W-1:0] RND_1    = CNT_W'(1);
  localparam logic [CNT_W-1:0] RND_2    = CNT_W'(2);
  localparam logic [CNT_W-1:0] RND_9    = CNT_W'(9);
  localparam logic [CNT_W-1:0] RND_16   = CNT_W'(16);
  localparam logic [CNT_W-1:0] RND_LAST = CNT_W'(ROUNDS);

  state_t            state_q, state_d;
  logic [31:0]       l_q, l_d, r_q, r_d;
  logic [55:0]       cd_q, cd_d, cd_rot;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mode_q, mode_d;
  logic [63:0]       out_data_q, out_data_d;
  logic [27:0]       c_cur, d_cur;
  logic              one_shift;

  always_comb begin
    c_cur     = cd_q[55:28];
    d_cur     = cd_q[27:0];
    one_shift = (cnt_q == RND_1) || (cnt_q == RND_2) || (cnt_q == RND_9) || (cnt_q == RND_16);
    cd_rot    = cd_q;
    if (!mode_q) begin
      if (one_shift) cd_rot = {c_cur[26:0], c_cur[27], d_cur[26:0], d_cur[27]};
      else           cd_rot = {c_cur[25:0], c_cur[27:26], d_cur[25:0], d_cur[27:26]};
    end else if (cnt_q != RND_1) begin
      // Decrypt walks the encrypt schedule backwards; its first key is C0||D0 itself.
      if (one_shift) cd_rot = {c_cur[0], c_cur[27:1], d_cur[0], d_cur[27:1]};
      else           cd_rot = {c_cur[1:0], c_cur[27:2], d_cur[1:0], d_cur[27:2]};
    end
  end

  always_comb begin
    state_d    = state_q;
    l_d        = l_q;
    r_d        = r_q;
    cd_d       = cd_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    out_data_d = out_data_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          l_d     = ip_data[63:32];
          r_d     = ip_data[31:0];
          cd_d    = key_cd;
          mode_d  = mode;
          cnt_d   = RND_1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        l_d   = r_q;
        r_d   = l_q ^ f_res;
        cd_d  = cd_rot;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == RND_LAST) begin
          out_data_d = {l_q ^ f_res, r_q};
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      l_q        <= '0;
      r_q        <= '0;
      cd_q       <= '0;
      cnt_q      <= '0;
      mode_q     <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      l_q        <= l_d;
      r_q        <= r_d;
      cd_q       <= cd_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      out_data_q <= out_data_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
  assign out_data  = out_data_q;
  assign f_r       = r_q;
  assign f_cd      = cd_rot;
  assign round_idx = (state_q == S_RUN) ? 4'(cnt_q) : 4'd0;

endmodule

// File: tb/tb_des_round_engine.sv
// Scoreboard bench for des_round_engine with a behavioural DES f-function
// (PC-2, E, S-boxes, P) answering f_r/f_cd combinationally.
module tb_des_round_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] ip_data = '0;
  logic [55:0] key_cd = '0;
  logic        mode = 1'b0;
  logic [31:0] f_r;
  logic [55:0] f_cd;
  logic [31:0] f_res;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_data;
  logic        busy;
  logic [3:0]  round_idx;

  localparam logic [55:0] KEY     = 56'hF0CCAAF_556678F;
  localparam logic [63:0] ENC_IN  = 64'hCC00CCFF_F0AAF0AA;
  localparam logic [63:0] ENC_OUT = 64'h0A4CD995_43423234;
  // Decrypting {R16,L16} unwinds to {R0,L0}; the final swap restores {L0,R0}.
  localparam logic [63:0] DEC_OUT = 64'hCC00CCFF_F0AAF0AA;

  des_round_engine #(.ROUNDS(16), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ip_data(ip_data), .key_cd(key_cd), .mode(mode), .f_r(f_r), .f_cd(f_cd),
    .f_res(f_res), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy), .round_idx(round_idx)
  );

  always #5 clk = ~clk;

  int pc2_t [0:47] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                       41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  int e_t [0:47] = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                     16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
  int p_t [0:31] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                     2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
  int sbox_t [0:511] = '{
    14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
    4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
    15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
    0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
    10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
    13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
    7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
    10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
    2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
    4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
    12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
    9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
    4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
    1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
    13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
    7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};
  int shift_t [0:15] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  function automatic logic [31:0] des_f(input logic [31:0] r, input logic [55:0] cd);
    logic [47:0] k, e, x;
    logic [31:0] s, p;
    logic [5:0]  b;
    int row, col;
    for (int j = 0; j < 48; j++) begin
      k[47-j] = cd[56-pc2_t[j]];
      e[47-j] = r[32-e_t[j]];
    end
    x = e ^ k;
    for (int i = 0; i < 8; i++) begin
      b   = x[47-6*i -: 6];
      row = int'({b[5], b[0]});
      col = int'(b[4:1]);
      s[31-4*i -: 4] = 4'(sbox_t[i*64 + row*16 + col]);
    end
    for (int j = 0; j < 32; j++) p[31-j] = s[32-p_t[j]];
    return p;
  endfunction

  assign f_res = des_f(f_r, f_cd);

  int checks = 0;
  int failures = 0;
  int edge_n = 0;
  int acc_cnt = 0;
  int lat_t;
  int rnd = 0;
  int acc_edges[$];
  int lat_q[$];
  logic [63:0] exp_q[$];
  logic        prev_valid = 1'b0;
  logic [55:0] cur_sched [1:16];
  logic [55:0] enc_sched [1:16];

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: bound expired", name);
  endtask

  always @(posedge clk) begin
    edge_n++;
    if (rst_n && in_valid && in_ready) begin
      acc_cnt++;
      acc_edges.push_back(edge_n);
      lat_q.push_back(edge_n);
    end
  end

  // Monitor: latency on each rising out_valid, data on each output handshake.
  always @(negedge clk) begin
    if (out_valid && !prev_valid) begin
      if (lat_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL spurious_out_valid: got 1 expected 0");
      end else begin
        lat_t = lat_q.pop_front();
        check_val("latency", 64'(edge_n - lat_t), 64'd16);
      end
    end
    prev_valid = out_valid;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_output: got %h expected none", out_data);
      end else check_val("out_data", out_data, exp_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (busy && !out_valid) begin
      rnd++;
      if (rnd <= 16) cur_sched[rnd] = f_cd;
      check_val("round_idx", 64'(round_idx), 64'(rnd % 16));
    end else rnd = 0;
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_accept(input int old, input string name);
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (acc_cnt != old) return;
    end
    fail_now(name);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0) return;
      @(posedge clk); #1;
    end
    fail_now(name);
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 40; i++) begin
      if (out_valid) return;
      @(posedge clk); #1;
    end
    fail_now(name);
  endtask

  // Issue one block; afterwards scramble the inputs that must no longer matter.
  task automatic issue(input logic [63:0] din, input logic m, input logic push, input logic [63:0] exp);
    int n;
    if (push) exp_q.push_back(exp);
    ip_data = din; key_cd = KEY; mode = m; in_valid = 1'b1;
    n = acc_cnt;
    wait_accept(n, "accept");
    in_valid = 1'b0;
    ip_data = 64'h5A5A_1234_DEAD_BEEF; key_cd = ~KEY; mode = ~m;
  endtask

  task automatic async_reset_check(input string tag);
    #3 rst_n = 1'b0;
    #1;
    check_val({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    check_val({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check_val({tag, "_out_data"}, out_data, 64'd0);
    check_val({tag, "_busy"}, 64'(busy), 64'd0);
    lat_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [27:0] c_m, d_m;
    logic [63:0] hold;
    #12;
    check_val("rst_in_ready", 64'(in_ready), 64'd1);
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_out_data", out_data, 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_round_idx", 64'(round_idx), 64'd0);
    check_val("rst_f_cd", 64'(f_cd), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Encrypt, then verify the key schedule seen on f_cd.
    out_ready = 1'b1;
    issue(ENC_IN, 1'b0, 1'b1, ENC_OUT);
    drain("enc_drain");
    for (int r = 1; r <= 16; r++) enc_sched[r] = cur_sched[r];
    check_val("sched_round1", 64'(enc_sched[1]), 64'(56'hE19955F_AACCF1E));
    check_val("sched_round16", 64'(enc_sched[16]), 64'(KEY));
    c_m = KEY[55:28]; d_m = KEY[27:0];
    for (int r = 1; r <= 16; r++) begin
      for (int s = 0; s < shift_t[r-1]; s++) begin
        c_m = {c_m[26:0], c_m[27]};
        d_m = {d_m[26:0], d_m[27]};
      end
      check_val("sched_enc", 64'(enc_sched[r]), 64'({c_m, d_m}));
    end

    // Decrypt uses the encrypt subkeys in reverse order.
    issue(ENC_OUT, 1'b1, 1'b1, DEC_OUT);
    drain("dec_drain");
    for (int r = 1; r <= 16; r++)
      check_val("sched_dec", 64'(cur_sched[r]), 64'(enc_sched[17-r]));

    // Backpressure with ignored in_valid pulses.
    out_ready = 1'b0;
    issue(ENC_IN, 1'b0, 1'b1, ENC_OUT);
    wait_valid("bp_valid");
    hold = out_data;
    check_val("bp_data", hold, ENC_OUT);
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2 == 0);
      ip_data  = {32'(i), 32'hFFFF_0000};
      @(posedge clk); #1;
      check_val("bp_stable", out_data, hold);
      check_val("bp_in_ready", 64'(in_ready), 64'd0);
      check_val("bp_out_valid", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_val("bp_release_idle", 64'(in_ready), 64'd1);
    check_val("bp_release_busy", 64'(busy), 64'd0);
    check_val("bp_popped", 64'(exp_q.size()), 64'd0);
    cycles(20);
    check_val("bp_no_extra", 64'(out_valid), 64'd0);

    // Reset mid-RUN, then reset while holding a result in DONE.
    issue(ENC_IN, 1'b0, 1'b0, 64'd0);
    cycles(5);
    check_val("mid_busy", 64'(busy), 64'd1);
    async_reset_check("rst_run");
    out_ready = 1'b0;
    issue(ENC_IN, 1'b0, 1'b0, 64'd0);
    wait_valid("done_valid");
    check_val("done_data", out_data, ENC_OUT);
    async_reset_check("rst_done");
    out_ready = 1'b1;
    cycles(20);
    check_val("post_rst_quiet", 64'(out_valid), 64'd0);

    // Back-to-back with in_valid held high.
    out_ready = 1'b1;
    acc_edges.delete();
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      int n;
      ip_data = (k % 2 == 0) ? ENC_IN : ENC_OUT;
      mode    = (k % 2 == 1);
      key_cd  = KEY;
      exp_q.push_back((k % 2 == 0) ? ENC_OUT : DEC_OUT);
      n = acc_cnt;
      wait_accept(n, "b2b_accept");
    end
    in_valid = 1'b0;
    drain("b2b_drain");
    check_val("b2b_count", 64'(acc_edges.size()), 64'd4);
    for (int k = 1; k < acc_edges.size(); k++)
      check_val("b2b_spacing", 64'(acc_edges[k] - acc_edges[k-1]), 64'd18);
    cycles(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
